// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Handles load-use hazards, branch squashes, data-memory wait sequencing and the timeout watchdog.
module pipe_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_BranchTaken,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_WriteReg,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Write,
  output logic             MEMWB_Bubble,
  output logic             dmem_req,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned WCW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t           r_state;
  logic [WCW-1:0]   r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             r_timeout;

  logic w_mem_acc;
  logic w_hazard;
  logic w_pc_write, w_ifid_write, w_ifid_flush, w_idex_flush;
  logic w_exmem_write, w_memwb_bubble, w_dmem_req;
  logic w_wait_last;

  assign w_mem_acc   = MEM_MemRead | MEM_MemWrite;
  assign w_hazard    = EX_MemRead && (EX_WriteReg != 5'd0) &&
                       ((EX_WriteReg == ID_Rs) || (ID_UsesRt && (EX_WriteReg == ID_Rt)));
  assign w_wait_last = (r_wait_cnt == WCW'(MAX_WAIT - 1));

  always_comb begin
    w_pc_write     = 1'b1;
    w_ifid_write   = 1'b1;
    w_ifid_flush   = 1'b0;
    w_idex_flush   = 1'b0;
    w_exmem_write  = 1'b1;
    w_memwb_bubble = 1'b0;
    w_dmem_req     = 1'b0;
    case (r_state)
      RUN, MEM_WAIT: begin
        // A pending memory access freezes the front end, so hazard/branch wait for ready.
        if (w_mem_acc || (r_state == MEM_WAIT)) w_dmem_req = 1'b1;
        if ((r_state == MEM_WAIT) ? !dmem_ready : (w_mem_acc && !dmem_ready)) begin
          w_pc_write     = 1'b0;
          w_ifid_write   = 1'b0;
          w_exmem_write  = 1'b0;
          w_memwb_bubble = 1'b1;
        end else if (w_hazard) begin
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_idex_flush = 1'b1;
        end else if (ID_BranchTaken) begin
          w_ifid_flush = 1'b1;
        end
      end
      default: begin
        w_pc_write     = 1'b0;
        w_ifid_write   = 1'b0;
        w_exmem_write  = 1'b0;
        w_memwb_bubble = 1'b1;
        w_idex_flush   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state        <= RUN;
      r_wait_cnt     <= '0;
      r_stall_cycles <= '0;
      r_timeout      <= 1'b0;
    end else begin
      if (!w_pc_write && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      case (r_state)
        RUN: begin
          if (w_mem_acc && !dmem_ready) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= WCW'(1);
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else if (w_wait_last) begin
            r_state   <= ERROR;
            r_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WCW'(1);
          end
        end
        default: begin
          r_state   <= ERROR;
          r_timeout <= 1'b1;
        end
      endcase
    end
  end

  // Combinational controls are masked so reset forces every output low immediately.
  assign PCWrite      = w_pc_write     & RSTn;
  assign IFID_Write   = w_ifid_write   & RSTn;
  assign IFID_Flush   = w_ifid_flush   & RSTn;
  assign IDEX_Flush   = w_idex_flush   & RSTn;
  assign EXMEM_Write  = w_exmem_write  & RSTn;
  assign MEMWB_Bubble = w_memwb_bubble & RSTn;
  assign dmem_req     = w_dmem_req     & RSTn;
  assign mem_timeout  = r_timeout      & RSTn;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; outputs are packed as
// {PCWrite,IFID_Write,IFID_Flush,IDEX_Flush,EXMEM_Write,MEMWB_Bubble,dmem_req,mem_timeout}.
module tb_pipe_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [4:0]  ID_Rs, ID_Rt, EX_WriteReg;
  logic        ID_UsesRt, ID_BranchTaken, EX_MemRead;
  logic        MEM_MemRead, MEM_MemWrite, dmem_ready;
  logic        PCWrite, IFID_Write, IFID_Flush, IDEX_Flush;
  logic        EXMEM_Write, MEMWB_Bubble, dmem_req, mem_timeout;
  logic [31:0] stall_cycles;
  logic [7:0]  outs;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  localparam logic [7:0] O_ZERO  = 8'h00;
  localparam logic [7:0] O_RUN   = 8'hC8;
  localparam logic [7:0] O_HAZ   = 8'h18;
  localparam logic [7:0] O_BR    = 8'hE8;
  localparam logic [7:0] O_MWAIT = 8'h06;
  localparam logic [7:0] O_MRDY  = 8'hCA;
  localparam logic [7:0] O_MRBR  = 8'hEA;
  localparam logic [7:0] O_ERR   = 8'h15;

  pipe_hazard_ctrl #(.MAX_WAIT(16), .CNT_W(32)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt), .ID_BranchTaken(ID_BranchTaken),
    .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .dmem_ready(dmem_ready),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
    .EXMEM_Write(EXMEM_Write), .MEMWB_Bubble(MEMWB_Bubble), .dmem_req(dmem_req),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  always #5 CLK = ~CLK;

  assign outs = {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush,
                 EXMEM_Write, MEMWB_Bubble, dmem_req, mem_timeout};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0; ID_BranchTaken = 1'b0;
    EX_MemRead = 1'b0; EX_WriteReg = 5'd0;
    MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; dmem_ready = 1'b0;
  endtask

  // Advance one clock; inputs change and outputs are sampled well clear of the edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    clr_inputs();
    RSTn = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      {ID_Rs, ID_Rt, EX_WriteReg} = 15'($urandom);
      {ID_UsesRt, ID_BranchTaken, EX_MemRead, MEM_MemRead, MEM_MemWrite, dmem_ready} = 6'($urandom);
      #2;
      check("reset_outs", 32'(outs), 32'(O_ZERO));
      check("reset_stall", stall_cycles, 32'd0);
      cyc();
    end
    clr_inputs();
    #1;
    RSTn = 1'b1;
    #1;
    check("release_run", 32'(outs), 32'(O_RUN));

    cyc();
    EX_MemRead = 1'b1; EX_WriteReg = 5'd5; ID_Rs = 5'd5;
    #2 check("loaduse_rs", 32'(outs), 32'(O_HAZ));
    cyc();
    check("loaduse_cnt", stall_cycles, 32'd1);
    clr_inputs();
    #2 check("loaduse_one_bubble", 32'(outs), 32'(O_RUN));
    cyc();

    EX_MemRead = 1'b1; EX_WriteReg = 5'd0; ID_Rs = 5'd0;
    #2 check("r0_no_hazard", 32'(outs), 32'(O_RUN));
    cyc();
    check("r0_cnt", stall_cycles, 32'd1);

    EX_MemRead = 1'b1; EX_WriteReg = 5'd7; ID_Rs = 5'd1; ID_Rt = 5'd7; ID_UsesRt = 1'b0;
    #2 check("rt_unused", 32'(outs), 32'(O_RUN));
    ID_UsesRt = 1'b1;
    #1 check("rt_used", 32'(outs), 32'(O_HAZ));
    EX_MemRead = 1'b0;
    #1 check("not_load", 32'(outs), 32'(O_RUN));
    EX_MemRead = 1'b1;
    cyc();
    check("rt_cnt", stall_cycles, 32'd2);

    ID_BranchTaken = 1'b1;
    #2 check("branch_vs_hazard", 32'(outs), 32'(O_HAZ));
    cyc();
    EX_MemRead = 1'b0;
    #2 check("branch_squash", 32'(outs), 32'(O_BR));
    cyc();
    check("branch_cnt", stall_cycles, 32'd3);
    clr_inputs();

    MEM_MemRead = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ID_BranchTaken = (i == 1);
      #2 check("mem_wait", 32'(outs), 32'(O_MWAIT));
      cyc();
    end
    ID_BranchTaken = 1'b1; dmem_ready = 1'b1;
    #2 check("mem_ready_branch", 32'(outs), 32'(O_MRBR));
    ID_BranchTaken = 1'b0;
    #1 check("mem_ready", 32'(outs), 32'(O_MRDY));
    cyc();
    check("mem_cnt", stall_cycles, 32'd6);
    #1 check("mem_ready_run", 32'(outs), 32'(O_MRDY));
    clr_inputs();
    #1 check("mem_done", 32'(outs), 32'(O_RUN));
    cyc();

    MEM_MemWrite = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #2 check("timeout_wait", 32'(outs), 32'(O_MWAIT));
      cyc();
    end
    #2 check("error_state", 32'(outs), 32'(O_ERR));
    check("error_cnt", stall_cycles, 32'd22);
    dmem_ready = 1'b1;
    cyc();
    #2 check("error_sticky", 32'(outs), 32'(O_ERR));
    check("error_cnt_more", stall_cycles, 32'd23);
    RSTn = 1'b0;
    #1 check("error_reset", 32'(outs), 32'(O_ZERO));
    check("error_reset_cnt", stall_cycles, 32'd0);
    cyc();
    clr_inputs();
    RSTn = 1'b1;
    #2 check("error_cleared", 32'(outs), 32'(O_RUN));
    cyc();

    MEM_MemRead = 1'b1; dmem_ready = 1'b0;
    #2 check("rmw_c1", 32'(outs), 32'(O_MWAIT));
    cyc();
    #2 check("rmw_c2", 32'(outs), 32'(O_MWAIT));
    RSTn = 1'b0;
    #1 check("rmw_reset", 32'(outs), 32'(O_ZERO));
    check("rmw_reset_cnt", stall_cycles, 32'd0);
    cyc();
    clr_inputs();
    RSTn = 1'b1;
    #2 check("rmw_run", 32'(outs), 32'(O_RUN));
    cyc();
    check("rmw_cnt", stall_cycles, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. Generates write-enable, flush and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves load-use hazards and taken-branch squashes.
- Sequences variable-latency data-memory accesses through a req/ready handshake, with a timeout watchdog.
- Keeps a saturating stall-cycle performance counter.

Parameters:
MAX_WAIT, 16, max cycles MEM_WAIT may last before a timeout is declared (>=2)
CNT_W, 32, width of stall_cycles counter

Ports:
CLK  in  1  pipeline clock, rising edge
RSTn  in  1  asynchronous active-low reset
ID_Rs  in  5  source reg 1 of instruction in ID
ID_Rt  in  5  source reg 2 of instruction in ID
ID_UsesRt  in  1  ID instruction reads Rt
ID_BranchTaken  in  1  branch resolved taken in ID
EX_MemRead  in  1  instruction in EX is a load
EX_WriteReg  in  5  destination reg of instruction in EX
MEM_MemRead  in  1  load in MEM stage
MEM_MemWrite  in  1  store in MEM stage
dmem_ready  in  1  data memory completes access this cycle
PCWrite  out  1  PC load enable
IFID_Write  out  1  IF/ID load enable
IFID_Flush  out  1  IF/ID loads NOP
IDEX_Flush  out  1  ID/EX loads bubble (all control bits 0)
EXMEM_Write  out  1  EX/MEM load enable
MEMWB_Bubble  out  1  MEM/WB loads RegWrite=0, MemtoReg=0
dmem_req  out  1  data memory access request
mem_timeout  out  1  sticky watchdog error flag
stall_cycles  out  CNT_W  count of cycles with PCWrite=0

Behaviour:
- Single clock CLK. Reset is asynchronous and active-low on RSTn.
- State register: RUN, MEM_WAIT, ERROR. Reset state is RUN; wait_cnt=0, stall_cycles=0.
- While RSTn=0, all outputs are forced to 0, regardless of other inputs.
- Control outputs are combinational from state and current inputs (Mealy). State and counters update on the CLK rising edge.
- mem_acc = MEM_MemRead | MEM_MemWrite.
- hazard = EX_MemRead & (EX_WriteReg!=0) & (EX_WriteReg==ID_Rs | (ID_UsesRt & EX_WriteReg==ID_Rt)).
- Default outputs in RUN: PCWrite=IFID_Write=EXMEM_Write=1; IFID_Flush=IDEX_Flush=MEMWB_Bubble=0.
- RUN, priority 1, mem_acc & !dmem_ready:
  - dmem_req=1.
  - PCWrite=IFID_Write=EXMEM_Write=0, MEMWB_Bubble=1.
  - Next state MEM_WAIT; wait_cnt<=1.
  - Load-use and branch are ignored this cycle because the front end is frozen.
- RUN, priority 2, hazard:
  - PCWrite=IFID_Write=0, IDEX_Flush=1. One bubble per occurrence.
  - ID_BranchTaken is ignored; the branch is re-evaluated next cycle.
- RUN, priority 3, ID_BranchTaken: IFID_Flush=1 (squash the fetched instruction). PC follows the branch target.
- RUN, mem_acc & dmem_ready: dmem_req=1, no stall.
- MEM_WAIT:
  - dmem_req=1 continuously.
  - If dmem_ready: default RUN enables apply, and hazard/branch rules above are evaluated this cycle. Next state RUN; wait_cnt<=0.
  - Else, if wait_cnt==MAX_WAIT-1: next state ERROR.
  - Else: hold the stall (same outputs as RUN priority 1); wait_cnt++.
- ERROR:
  - All enables 0, dmem_req=0, MEMWB_Bubble=1, IDEX_Flush=1.
  - mem_timeout=1 (registered, sticky). Exit only via RSTn.
- dmem_req never drops between request and ready. The MEM-stage inputs are stable during MEM_WAIT because EX/MEM is held.
- stall_cycles increments on each clock where PCWrite=0 and RSTn=1. Saturates at all-ones.
- Reset asserted mid-MEM_WAIT: immediate return to RUN, outputs 0, counters cleared. No req is held across reset.
- EX_WriteReg==0 never triggers a hazard. An ID_Rt match is ignored when ID_UsesRt=0.

Test Plan:
- Reset: hold RSTn=0 with random inputs -> all outputs 0. Release -> PCWrite=IFID_Write=EXMEM_Write=1, state RUN.
- Load-use: EX_MemRead=1, EX_WriteReg=5, ID_Rs=5 for one cycle -> PCWrite=0, IFID_Write=0, IDEX_Flush=1 for exactly 1 cycle; stall_cycles 0->1. Same stimulus with EX_WriteReg=0 -> no stall.
- Branch vs hazard: ID_BranchTaken=1 with hazard true -> IFID_Flush=0, IDEX_Flush=1. Next cycle, hazard false and branch still taken -> IFID_Flush=1, PCWrite=1.
- Memory wait: MEM_MemRead=1, dmem_ready low for 3 cycles then high -> dmem_req=1 for 4 cycles, EXMEM_Write=0 and MEMWB_Bubble=1 for 3 cycles, release on cycle 4; stall_cycles +=3.
- Timeout: MEM_MemWrite=1, dmem_ready never asserted, MAX_WAIT=16 -> ERROR entered after 16 stalled cycles; mem_timeout=1 sticky, dmem_req=0. Asserting RSTn=0 clears it.
- Reset mid-wait: RSTn low during cycle 2 of MEM_WAIT -> outputs 0 immediately. After release, state RUN and stall_cycles=0.
